// File: rtl/uart_io_unit.sv
// Byte-level UART buffering for the execute stage: RX/TX FIFOs, IN/OUT byte and word ops, TX drain to uart_tx.
// IN byte/OUT byte complete two cycles after req; ops stall on an empty RX FIFO or a full TX FIFO.
module uart_io_unit #(
   parameter int         RX_AW      = 11,
   parameter int         TX_AW      = 11,
   parameter int         WORD_BYTES = 4,
   parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic [1:0]       i_op,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   output logic             o_busy,
   output logic             o_done,
   input  logic             i_rx_enable,
   input  logic [7:0]       i_rx_byte,
   input  logic             i_rx_valid,
   output logic [7:0]       o_tx_byte,
   output logic             o_tx_start,
   input  logic             i_tx_busy,
   output logic             o_sync_seen,
   output logic             o_rx_overflow,
   input  logic             i_clr_err,
   output logic [RX_AW:0]   o_rx_count,
   output logic [TX_AW:0]   o_tx_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} cpu_state_t;
   typedef enum logic {T_IDLE, T_WAIT} tx_state_t;

   localparam logic [1:0] LAST_WORD = 2'(WORD_BYTES - 1);

   logic [7:0]     r_rx_mem [2**RX_AW];
   logic [7:0]     r_tx_mem [2**TX_AW];
   logic [RX_AW:0] r_rx_wptr, r_rx_rptr, r_rx_count;
   logic [TX_AW:0] r_tx_wptr, r_tx_rptr, r_tx_count;
   logic           r_rx_overflow, r_sync_seen;

   cpu_state_t     r_state;
   tx_state_t      r_tstate;
   logic [1:0]     r_op, r_idx;
   logic [31:0]    r_wdata, r_asm, r_rdata;
   logic           r_done, r_tx_start;
   logic [7:0]     r_tx_byte;

   logic           w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic           w_rx_push, w_rx_drop, w_rx_pop, w_tx_push, w_tx_pop;
   logic           w_run, w_is_in, w_xfer;
   logic [1:0]     w_last;
   logic [4:0]     w_lane;
   logic [7:0]     w_rx_head, w_tx_head, w_out_byte;
   logic [31:0]    w_asm_next;

   assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
   assign w_rx_full  = (r_rx_wptr[RX_AW] != r_rx_rptr[RX_AW]) &&
                       (r_rx_wptr[RX_AW-1:0] == r_rx_rptr[RX_AW-1:0]);
   assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
   assign w_tx_full  = (r_tx_wptr[TX_AW] != r_tx_rptr[TX_AW]) &&
                       (r_tx_wptr[TX_AW-1:0] == r_tx_rptr[TX_AW-1:0]);

   assign w_run      = (r_state == S_RUN);
   assign w_is_in    = !r_op[1];
   assign w_last     = r_op[0] ? LAST_WORD : 2'd0;
   assign w_rx_push  = i_rx_valid && i_rx_enable && !w_rx_full;
   assign w_rx_drop  = i_rx_valid && i_rx_enable && w_rx_full;
   assign w_rx_pop   = w_run && w_is_in && !w_rx_empty;
   assign w_tx_push  = w_run && !w_is_in && !w_tx_full;
   assign w_xfer     = w_rx_pop || w_tx_push;
   assign w_tx_pop   = (r_tstate == T_IDLE) && !w_tx_empty && !i_tx_busy;

   assign w_rx_head  = r_rx_mem[r_rx_rptr[RX_AW-1:0]];
   assign w_tx_head  = r_tx_mem[r_tx_rptr[TX_AW-1:0]];
   assign w_lane     = {r_idx, 3'b000};
   assign w_out_byte = r_wdata[w_lane +: 8];

   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[w_lane +: 8] = w_rx_head;
   end

   always_ff @(posedge i_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr[RX_AW-1:0]] <= i_rx_byte;
      if (w_tx_push) r_tx_mem[r_tx_wptr[TX_AW-1:0]] <= w_out_byte;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_wptr     <= '0;
         r_rx_rptr     <= '0;
         r_rx_count    <= '0;
         r_tx_wptr     <= '0;
         r_tx_rptr     <= '0;
         r_tx_count    <= '0;
         r_rx_overflow <= 1'b0;
         r_sync_seen   <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         r_rx_count <= r_rx_count + (RX_AW+1)'(w_rx_push) - (RX_AW+1)'(w_rx_pop);
         r_tx_count <= r_tx_count + (TX_AW+1)'(w_tx_push) - (TX_AW+1)'(w_tx_pop);
         // A drop in the same cycle as clr_err leaves the flag set
         if (w_rx_drop)      r_rx_overflow <= 1'b1;
         else if (i_clr_err) r_rx_overflow <= 1'b0;
         r_sync_seen <= i_rx_valid && (i_rx_byte == SYNC_BYTE);
      end
   end

   // T_WAIT gives uart_tx a cycle to raise busy before the next head is considered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tstate   <= T_IDLE;
         r_tx_start <= 1'b0;
         r_tx_byte  <= 8'h00;
      end else begin
         r_tx_start <= 1'b0;
         case (r_tstate)
            T_IDLE: if (w_tx_pop) begin
               r_tx_byte  <= w_tx_head;
               r_tx_start <= 1'b1;
               r_tstate   <= T_WAIT;
            end
            default: r_tstate <= T_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_op    <= 2'b00;
         r_idx   <= 2'd0;
         r_wdata <= '0;
         r_asm   <= '0;
         r_rdata <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_req) begin
               r_op    <= i_op;
               r_wdata <= i_wdata;
               r_idx   <= 2'd0;
               r_asm   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: if (w_xfer) begin
               if (w_is_in) r_asm <= w_asm_next;
               if (r_idx == w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  if (w_is_in) r_rdata <= w_asm_next;
               end else begin
                  r_idx <= r_idx + 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = i_req | (r_state != S_IDLE);
   assign o_done        = r_done;
   assign o_rdata       = r_rdata;
   assign o_tx_byte     = r_tx_byte;
   assign o_tx_start    = r_tx_start;
   assign o_sync_seen   = r_sync_seen;
   assign o_rx_overflow = r_rx_overflow;
   assign o_rx_count    = r_rx_count;
   assign o_tx_count    = r_tx_count;

endmodule
